// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// One radix-2 shift-add (MULT/MULTU) or restoring shift-subtract (DIV/DIVU) step per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               sa;
    logic               sb;
    logic               dz;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    assign busy = (state != S_IDLE);

    always_comb begin
        a_neg     = ~op[0] & a[WIDTH-1];
        b_neg     = ~op[0] & b[WIDTH-1];
        abs_a     = a_neg ? -a : a;
        abs_b     = b_neg ? -b : b;
        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_add   = acc[0] ? opnd : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Divide: acc = {remainder, dividend bits shifting into quotient bits}
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        prod_res  = (sa ^ sb) ? -acc : acc;
        quo_res   = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_res   = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hilo_we[1]) hi <= hilo_wdata;
                    if (hilo_we[0]) lo <= hilo_wdata;
                    if (start && !flush) begin
                        is_div <= op[1];
                        sa     <= a_neg;
                        sb     <= b_neg;
                        count  <= CW'(WIDTH);
                        if (op[1]) begin
                            opnd  <= abs_b;
                            acc   <= {{WIDTH{1'b0}}, abs_a};
                            dz    <= (b == '0);
                            state <= (b == '0) ? S_DONE : S_DIV;
                        end else begin
                            opnd  <= abs_a;
                            acc   <= {{WIDTH{1'b0}}, abs_b};
                            dz    <= 1'b0;
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= (state == S_MUL) ? mul_next : div_next;
                        count <= count - CW'(1);
                        if (count == CW'(1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Commit is held back to the DONE exit edge so a flush in DONE can still cancel it.
                    state <= S_IDLE;
                    if (!flush) begin
                        done     <= 1'b1;
                        div_zero <= dz;
                        if (!dz) begin
                            if (is_div) begin
                                hi <= rem_res;
                                lo <= quo_res;
                            end else begin
                                {hi, lo} <= prod_res;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): table vectors, random model vectors,
// and hand-written flush/reset/busy sequences, with a scoreboard queue of expected results.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic         flush;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   hilo_we;
    logic [W-1:0] hilo_wdata;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   we;
        logic [W-1:0] wd;
        logic         poke;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edz;
    } vec_t;

    typedef struct {
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edz;
        int           elat;
    } exp_t;

    exp_t         sb_q[$];
    vec_t         tbl[8];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] eh, input logic [W-1:0] el);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.we = 2'b00; v.wd = '0; v.poke = 1'b0;
        v.ehi = eh; v.elo = el; v.edz = 1'b0;
        return v;
    endfunction

    // Reference arithmetic for random vectors, independent of the shift/add structure.
    function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t v;
        logic signed [63:0]  p;
        logic [63:0]         pu;
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        v = mk(o, x, y, mhi, mlo);
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                v.ehi = p[63:32]; v.elo = p[31:0];
            end
            2'b01: begin
                pu = {32'b0, x} * {32'b0, y};
                v.ehi = pu[63:32]; v.elo = pu[31:0];
            end
            2'b10: begin
                if (y == '0) v.edz = 1'b1;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    v.elo = x; v.ehi = '0;
                end else begin
                    v.elo = sx / sy; v.ehi = sx % sy;
                end
            end
            default: begin
                if (y == '0) v.edz = 1'b1;
                else begin
                    v.elo = x / y; v.ehi = x % y;
                end
            end
        endcase
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        e.ehi  = v.ehi;
        e.elo  = v.elo;
        e.edz  = v.edz;
        e.elat = v.edz ? 1 : W + 1;
        sb_q.push_back(e);
        if (v.we[1]) mhi = v.wd;
        if (v.we[0]) mlo = v.wd;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; start = 1'b1;
        hilo_we = v.we; hilo_wdata = v.wd;
        @(posedge clk); #1;
        start = 1'b0; hilo_we = 2'b00;
        op = 2'($urandom); a = $urandom; b = $urandom;
        check("busy_after_accept", busy, 1);
        check("hi_held_during_op", hi, mhi);
        check("lo_held_during_op", lo, mlo);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (v.poke && lat == 5) begin
                start = 1'b1; op = 2'b11; b = '0;
                hilo_we = 2'b11; hilo_wdata = 32'hDEAD_BEEF;
            end else if (v.poke && lat == 6) begin
                start = 1'b0; hilo_we = 2'b00;
            end
        end
        got = sb_q.pop_front();
        check("latency", lat, got.elat);
        check("hi", hi, got.ehi);
        check("lo", lo, got.elo);
        check("div_zero", div_zero, got.edz);
        mhi = got.ehi;
        mlo = got.elo;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    task automatic watch_no_done(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("no_done_pulse", seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; op = '0; flush = 1'b0; a = '0; b = '0;
        hilo_we = 2'b00; hilo_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        rst = 1'b0;

        tbl[0] = mk(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        tbl[1] = mk(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tbl[2] = mk(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tbl[3] = mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        tbl[4] = mk(2'b11, 32'h0000_0100, 32'h0000_0007, 32'h0000_0004, 32'h0000_0024);
        tbl[5] = mk(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        tbl[6] = mk(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        tbl[7] = mk(2'b01, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000);
        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        for (int i = 0; i < 8; i++) run_op(model(2'($urandom), $urandom, $urandom | 32'h1));

        // HI/LO preset, then divide by zero leaves them untouched
        @(negedge clk); hilo_we = 2'b10; hilo_wdata = 32'h11;
        @(negedge clk); hilo_we = 2'b01; hilo_wdata = 32'h22;
        @(negedge clk); hilo_we = 2'b00;
        mhi = 32'h11; mlo = 32'h22;
        check("preset_hi", hi, 32'h11);
        check("preset_lo", lo, 32'h22);
        v = mk(2'b11, 32'h1234, 32'h0, 32'h11, 32'h22);
        v.edz = 1'b1;
        run_op(v);

        // HI/LO write in the accepting cycle is later overwritten by the result
        v = mk(2'b01, 32'h5, 32'h7, 32'h0, 32'h23);
        v.we = 2'b11; v.wd = 32'hAA;
        run_op(v);

        // start and hilo_we while busy are dropped
        v = mk(2'b00, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FF00);
        v.poke = 1'b1;
        run_op(v);
        check("poke_not_queued_busy", busy, 0);

        // flush mid-MUL
        @(negedge clk); op = 2'b01; a = 32'h5; b = 32'h7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_mul_idle", busy, 0);
        watch_no_done(40);
        check("flush_mul_hi", hi, mhi);
        check("flush_mul_lo", lo, mlo);
        run_op(mk(2'b01, 32'h5, 32'h7, 32'h0, 32'h23));

        // flush in DONE cancels the commit
        @(negedge clk); op = 2'b00; a = 32'h3; b = 32'h3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (W) begin @(posedge clk); #1; end
        check("done_state_busy", busy, 1);
        check("done_state_no_pulse_yet", done, 0);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_done_idle", busy, 0);
        check("flush_done_pulse", done, 0);
        check("flush_done_lo", lo, mlo);
        watch_no_done(5);

        // flush and start together in IDLE: start dropped
        @(negedge clk); op = 2'b01; a = 32'h2; b = 32'h2; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("flush_beats_start", busy, 0);

        // reset mid-DIVU, with a HI/LO write also asserted
        @(negedge clk); op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1; hilo_we = 2'b11; hilo_wdata = 32'h5555_5555; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; hilo_we = 2'b00; start = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        mhi = '0; mlo = '0;
        watch_no_done(40);
        run_op(mk(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
